mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//   Multi-cycle multiply/divide unit in the EX stage, beside the 32-bit ALU and fed the same
//   forwarded SrcA/SrcB operands. Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO into the HI/LO pair.
//   Raises Busy so hazard logic stalls MFHI/MFLO and further MDU ops until the result lands.
// PARAMETERS
//   MULT_CYCLES  5   cycles from accepted MULT/MULTU to HI/LO update (>=1)
//   DIV_CYCLES   10  cycles from accepted DIV/DIVU to HI/LO update (>=1)
// PORTS
//   clk      in   1   single clock, all state on rising edge
//   rst_n    in   1   asynchronous, active-low reset
//   SrcA     in   32  operand A (dividend / multiplicand / MTHI-MTLO data)
//   SrcB     in   32  operand B (divisor / multiplier)
//   MDUOp    in   3   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 reserved(=NONE)
//   Start    in   1   request: sample MDUOp/SrcA/SrcB this edge
//   Cancel   in   1   exception flush: abort in-flight op, discard its result
//   Busy     out  1   registered; high while a MULT/DIV op is in flight
//   HI       out  32  HI register
//   LO       out  32  LO register
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, counter=0, Busy=0, HI=0, LO=0, pending result=0.
//   States: IDLE, MUL, DIV.
//   IDLE: Start & !Cancel & op MULT/MULTU -> latch result, counter=MULT_CYCLES, go MUL, Busy=1.
//         Start & !Cancel & op DIV/DIVU   -> latch result, counter=DIV_CYCLES, go DIV, Busy=1.
//         Start & !Cancel & MTHI -> HI<=SrcA at this edge; MTLO -> LO<=SrcA; stay IDLE, Busy=0.
//         NONE/reserved op, or Start=0 -> no change.
//   MUL/DIV: counter decrements each edge; on edge where counter==1: HI/LO <= pending,
//         Busy<=0, state<=IDLE. Start sampled at edge k -> Busy=1 after edges k..k+N-1,
//         HI/LO visible and Busy=0 after edge k+N (N=MULT_CYCLES or DIV_CYCLES).
//   Start while Busy: ignored entirely (incl. MTHI/MTLO); hazard logic guarantees it stalls.
//   Busy is registered, so in the Start cycle Busy=0; hazard logic ORs Start itself.
//   Cancel: any state -> IDLE next edge, Busy<=0, HI/LO keep pre-op values. Cancel same
//     cycle as Start: Start ignored (no MTHI/MTLO write either). Cancel on the completion
//     edge wins: no HI/LO write.
//   Arithmetic, operands latched at Start (later SrcA/SrcB changes have no effect):
//     MULT: {HI,LO}=signed 32x32->64; MULTU: unsigned 32x32->64.
//     DIV: LO=quotient truncated toward zero, HI=remainder with sign of dividend.
//     DIVU: unsigned quotient/remainder.
//     Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//     Divide by zero (SrcB==0): full DIV_CYCLES Busy, then HI/LO unchanged.
//   Product/quotient may be computed combinationally at Start and held in pending regs;
//     counter only models latency. No X may reach HI/LO.
//   Reset asserted mid-operation: immediate return to reset values; no partial write.
// TESTING
//   1 Reset: rst_n=0 async mid-cycle -> Busy=0, HI=LO=0 before next clk edge.
//   2 MULT 0xFFFFFFFE*3 (signed) -> Busy high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFA;
//     MULTU same operands -> HI=0x00000002 LO=0xFFFFFFFA.
//   3 DIV -7/2 -> after 10 cycles LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU 7/2 -> LO=3 HI=1;
//     DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000 HI=0.
//   4 MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back -> HI/LO updated next edge each,
//     Busy stays 0; DIV by zero after -> Busy 10 cycles, HI/LO still 0x12345678/0x9ABCDEF0.
//   5 MULT started, Start+MTLO on cycle 2 (ignored), Cancel on cycle 3 -> Busy=0 next edge,
//     HI/LO unchanged; Start+Cancel same cycle -> nothing changes.
//   6 Operand hold: change SrcA/SrcB every cycle during a MULT -> result matches latched values.

Source files
------------

// File: rtl/mdu_if.sv
// Operand/result bundle between the EX-stage issue logic and the multiply/divide unit.
// No latency of its own: pure wiring.
// The master drives operands and requests; the slave answers with Busy and HI/LO.
interface mdu_if;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [2:0]  MDUOp;
   logic        Start;
   logic        Cancel;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output SrcA, SrcB, MDUOp, Start, Cancel,
      input  Busy, HI, LO
   );

   modport slave (
      input  SrcA, SrcB, MDUOp, Start, Cancel,
      output Busy, HI, LO
   );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit writing the HI/LO pair.
// Latency: MTHI/MTLO land on the Start edge; MULT after MULT_CYCLES, DIV after DIV_CYCLES edges.
// No backpressure: Start while Busy is dropped; hazard logic stalls on Busy (or Start).
module mul_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic rst_n,
   mdu_if.slave mdu
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic           busy_q;
   logic [31:0]    hi_q, lo_q;
   logic [63:0]    pend_q, pend_d;     // {HI,LO} waiting for the latency to expire
   logic           pend_vld_q, pend_vld_d; // clear for divide-by-zero: no write at completion

   logic          accept;
   logic [31:0]   a, b, div_b, abs_a, abs_b, uq, ur, sq, sr;
   logic [63:0]   prod_s, prod_u;

   assign a      = mdu.SrcA;
   assign b      = mdu.SrcB;
   assign accept = (state_q == S_IDLE) && mdu.Start && !mdu.Cancel;

   // Arithmetic on the live operands; only the value present on the Start edge is kept.
   // A zero divisor is replaced by 1 so no X ever leaves the divider.
   always_comb begin
      prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_u = {32'd0, a} * {32'd0, b};
      div_b  = (b == 32'd0) ? 32'd1 : b;
      abs_a  = a[31] ? -a : a;
      abs_b  = div_b[31] ? -div_b : div_b;
      uq     = abs_a / abs_b;
      ur     = abs_a % abs_b;
      // 0x80000000 / -1 yields magnitude 0x80000000, whose negation is itself: no special case.
      sq     = (a[31] ^ div_b[31]) ? -uq : uq;
      sr     = a[31] ? -ur : ur;
   end

   // Select the result to hold in the pending registers for an accepted MULT/DIV.
   always_comb begin
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (accept) begin
         case (mdu.MDUOp)
            OP_MULT:  begin pend_d = prod_s;                pend_vld_d = 1'b1; end
            OP_MULTU: begin pend_d = prod_u;                pend_vld_d = 1'b1; end
            OP_DIV:   begin pend_d = {sr, sq};              pend_vld_d = (b != 32'd0); end
            OP_DIVU:  begin pend_d = {a % div_b, a / div_b}; pend_vld_d = (b != 32'd0); end
            default:  ;
         endcase
      end
   end

   // Control FSM: issue, latency countdown, completion write, cancel flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
      end else if (mdu.Cancel) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         case (state_q)
            S_IDLE: begin
               if (mdu.Start) begin
                  case (mdu.MDUOp)
                     OP_MULT, OP_MULTU: begin
                        cnt_q   <= CW'(MULT_CYCLES);
                        state_q <= S_MUL;
                        busy_q  <= 1'b1;
                     end
                     OP_DIV, OP_DIVU: begin
                        cnt_q   <= CW'(DIV_CYCLES);
                        state_q <= S_DIV;
                        busy_q  <= 1'b1;
                     end
                     OP_MTHI: hi_q <= a;
                     OP_MTLO: lo_q <= a;
                     default: ;
                  endcase
               end
            end
            S_MUL, S_DIV: begin
               if (cnt_q == CW'(1)) begin
                  if (pend_vld_q) begin
                     hi_q <= pend_q[63:32];
                     lo_q <= pend_q[31:0];
                  end
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mdu.Busy = busy_q;
   assign mdu.HI   = hi_q;
   assign mdu.LO   = lo_q;

endmodule
